// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit holding the HI/LO register pair.
// MULT/MULTU use a shift-add loop over a 2*WIDTH accumulator and
// DIV/DIVU use a restoring divider. Both work on operand magnitudes.
// The signs are put back in a final fix-up cycle.
//
// Handshake: start is sampled only while the unit is idle (busy=0).
// A start seen while busy is dropped, not queued. done pulses for one
// cycle when hi/lo take a result. In that same cycle busy is already
// low, so a new start can be accepted back-to-back.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  // Multiplicand for multiply, divisor for divide (magnitude).
  logic [WIDTH-1:0]   oper;
  // Multiply: {partial high, multiplier/product low}.
  // Divide:   {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign busy      = (state != S_IDLE);
  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];

  // Operand magnitudes. The most-negative value maps to itself, and that
  // is the correct unsigned magnitude.
  always_comb begin
    abs_a = a_r;
    abs_b = b_r;
    if (is_signed && a_r[WIDTH-1]) abs_a = -a_r;
    if (is_signed && b_r[WIDTH-1]) abs_b = -b_r;
  end

  // One iteration of shift-add multiply and of restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, oper};
    div_ge    = (div_shift >= {1'b0, oper});
    if (div_ge) div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else        div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign fix-up and the divide-by-zero override, used in the FIX state.
  always_comb begin
    prod = neg_lo ? -acc : acc;
    quo  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = a_r;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  // Control FSM, datapath registers and the HI/LO pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      oper     <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          // Product and quotient share the same sign rule.
          // The remainder takes the sign of the dividend.
          neg_lo   <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_hi   <= is_signed & a_r[WIDTH-1];
          div_zero <= (b_r == '0);
          if (is_div) begin
            acc  <= {{WIDTH{1'b0}}, abs_a};
            oper <= abs_b;
          end else begin
            acc  <= {{WIDTH{1'b0}}, abs_b};
            oper <= abs_a;
          end
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32).
// The driver pushes each expected {hi,lo} into a queue when it issues a
// start. A monitor pops and compares that value whenever done pulses.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] exp_q[$];
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;
  int          n_assert;
  int          n_fail;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour built from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      2'b00: p = 64'(sx * sy);
      2'b01: p = {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) check("spurious_done", 64'(done), 64'h0);
      else check("result", {hi, lo}, exp_q.pop_front());
    end
  end

  // Issue one operation, optionally with MTHI/MTLO in the start cycle.
  // poke > 0 injects start+hi_we+lo_we at that busy cycle, which must be ignored.
  // Returns at the negedge where done is seen, so a following call is back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic wr_hi, input logic wr_lo, input logic [31:0] wd,
                        input int poke);
    logic [63:0] e;
    int          cyc;
    e     = model(o, x, y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    hi_we = wr_hi;
    lo_we = wr_lo;
    wdata = wd;
    if (wr_hi) mdl_hi = wd;
    if (wr_lo) mdl_lo = wd;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
    wdata = $urandom;
    cyc   = 1;
    while (!done && cyc < 60) begin
      check("busy_in_run", 64'(busy), 64'h1);
      check("hold_hi", 64'(hi), 64'(mdl_hi));
      check("hold_lo", 64'(lo), 64'(mdl_lo));
      if (cyc == poke) begin
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("latency", 64'(cyc), 64'd35);
    check("busy_at_done", 64'(busy), 64'h0);
    mdl_hi = e[63:32];
    mdl_lo = e[31:0];
  endtask

  initial begin
    int          seen;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    n_assert = 0;
    n_fail   = 0;
    mdl_hi   = '0;
    mdl_lo   = '0;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    a        = '0;
    b        = '0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    wdata    = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operations, issued back-to-back.
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0, 32'h0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 32'h0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 0);
    run_op(2'b11, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 0);
    run_op(2'b10, 32'h8765_4321, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 0);

    // Random operations, with an occasional zero divisor.
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      run_op(ro, ra, rb, 1'b0, 1'b0, 32'h0, 0);
    end
    @(negedge clk);

    // MTLO alone, then MTHI and MTLO together, in IDLE.
    lo_we = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(negedge clk);
    lo_we  = 1'b0;
    mdl_lo = 32'hCAFE_F00D;
    check("mtlo_lo", 64'(lo), 64'h0000_0000_CAFE_F00D);
    check("mtlo_hi", 64'(hi), 64'(mdl_hi));
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h0BAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mtboth", {hi, lo}, 64'h0BAD_BEEF_0BAD_BEEF);
    mdl_hi = 32'h0BAD_BEEF;
    mdl_lo = 32'h0BAD_BEEF;

    // MTHI in the same cycle as an accepted start; the hold checks see the write.
    run_op(2'b01, 32'h0001_0003, 32'h0002_0005, 1'b1, 1'b0, 32'h5555_AAAA, 0);

    // A start plus MTHI/MTLO during busy must be ignored.
    run_op(2'b00, 32'h0000_1234, 32'hFFFF_FF00, 1'b0, 1'b0, 32'h0, 5);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("ignored_start", 64'(seen), 64'h0);
    check("ignored_write", {hi, lo}, {mdl_hi, mdl_lo});

    // Reset in RUN cycle 10 discards the operation.
    start = 1'b1;
    op    = 2'b01;
    a     = 32'h7654_3210;
    b     = 32'h0000_0F0F;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("busy_before_rst", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_done", 64'(done), 64'h0);
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'h0);
    check("hilo_after_rst", {hi, lo}, 64'h0);

    // One more operation to confirm recovery after reset.
    run_op(2'b10, 32'hFFFF_FF9C, 32'h0000_0007, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
